// File: rtl/puc_pkg.sv
// Shared definitions for the PUC CPU: instruction fields, opcodes, program memory states
// and the built-in boot image.
package puc_pkg;

    localparam int unsigned REG_WIDTH       = 3;
    localparam int unsigned IMM_WIDTH       = 8;
    localparam int unsigned BOOT_WORD_WIDTH = 16;
    localparam int unsigned OPCODE_WIDTH    = BOOT_WORD_WIDTH - REG_WIDTH - IMM_WIDTH;

    typedef logic [OPCODE_WIDTH-1:0] opcode_t;

    localparam opcode_t LOADI = opcode_t'(1);
    localparam opcode_t MOVE  = opcode_t'(2);
    localparam opcode_t ADD   = opcode_t'(3);
    localparam opcode_t JUMP  = opcode_t'(4);
    localparam opcode_t RESET = opcode_t'(31);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StLoad
    } pm_state_t;

    // Boot image word for a given address; {opcode, reg, imm}, zero elsewhere.
    function automatic logic [BOOT_WORD_WIDTH-1:0] boot_word(input int unsigned addr);
        logic [REG_WIDTH-1:0] r1;
        r1 = REG_WIDTH'(1);
        case (addr)
            1:       boot_word = {LOADI, r1, IMM_WIDTH'(3)};
            2:       boot_word = {MOVE,  r1, IMM_WIDTH'(0)};
            3:       boot_word = {LOADI, r1, IMM_WIDTH'(1)};
            4:       boot_word = {ADD,   r1, IMM_WIDTH'(0)};
            5:       boot_word = {JUMP,  r1, IMM_WIDTH'(4)};
            6:       boot_word = {LOADI, r1, IMM_WIDTH'(1)};
            7:       boot_word = {ADD,   r1, IMM_WIDTH'(0)};
            8:       boot_word = {RESET, r1, IMM_WIDTH'(0)};
            default: boot_word = '0;
        endcase
    endfunction

endpackage

// File: rtl/program_ram.sv
// Single-port-write, registered-read instruction RAM. The array itself has no reset; only
// the read register does. Addresses at or beyond DEPTH are never written and read as zero.
module program_ram #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array write, dropping out-of-range addresses.
    always_ff @(posedge clk) begin
        if (we_i && (32'(waddr_i) < DEPTH)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/program_memory.sv
// Writable instruction store: boots a built-in image into RAM after reset, serves
// one-cycle registered fetches, and accepts little-endian byte-streamed programs.
module program_memory
    import puc_pkg::*;
#(
    parameter int unsigned PC_WIDTH          = 4,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned INSTRUCTION_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fetch_req,
    input  logic [PC_WIDTH-1:0]          pc,
    output logic                         fetch_ready,
    output logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         instruction_valid,
    input  logic                         load_start,
    input  logic [PC_WIDTH-1:0]          load_addr,
    input  logic [7:0]                   load_data,
    input  logic                         load_valid,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic                         busy,
    output logic                         load_wrapped
);

    localparam int unsigned BYTES = INSTRUCTION_WIDTH / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    pm_state_t                    state_q;
    logic [PC_WIDTH-1:0]          boot_cnt_q;
    logic [PC_WIDTH-1:0]          load_addr_q;
    logic [IDX_W-1:0]             byte_idx_q;
    logic [INSTRUCTION_WIDTH-1:0] asm_q;
    logic                         last_q;
    logic                         wr_pend_q;
    logic [PC_WIDTH-1:0]          wr_addr_q;
    logic [INSTRUCTION_WIDTH-1:0] wr_data_q;
    logic                         fetch_ready_q;
    logic                         load_ready_q;
    logic                         busy_q;
    logic                         wrapped_q;
    logic                         instr_valid_q;

    logic                         fetch_acc;
    logic                         byte_acc;
    logic                         word_full;
    logic                         addr_at_end;
    logic [PC_WIDTH-1:0]          addr_next;
    logic [INSTRUCTION_WIDTH-1:0] asm_next;
    logic                         ram_we;
    logic [PC_WIDTH-1:0]          ram_waddr;
    logic [INSTRUCTION_WIDTH-1:0] ram_wdata;

    // Handshakes, byte assembly and load-address wrap.
    always_comb begin
        fetch_acc   = fetch_req & fetch_ready_q;
        byte_acc    = load_valid & load_ready_q;
        word_full   = (byte_idx_q == IDX_W'(BYTES - 1));
        addr_at_end = (load_addr_q == PC_WIDTH'(DEPTH - 1));
        addr_next   = addr_at_end ? '0 : load_addr_q + PC_WIDTH'(1);
        // asm_q is cleared at each word start, so OR-ing leaves unfilled bytes zero.
        asm_next    = asm_q | (INSTRUCTION_WIDTH'(load_data) << {byte_idx_q, 3'b000});
    end

    // RAM write port: boot image during BOOT, otherwise the delayed loader write.
    always_comb begin
        ram_we    = wr_pend_q;
        ram_waddr = wr_addr_q;
        ram_wdata = wr_data_q;
        if (state_q == StBoot) begin
            ram_we    = 1'b1;
            ram_waddr = boot_cnt_q;
            ram_wdata = INSTRUCTION_WIDTH'(boot_word(32'(boot_cnt_q)));
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            boot_cnt_q    <= '0;
            load_addr_q   <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            last_q        <= 1'b0;
            wr_pend_q     <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            fetch_ready_q <= 1'b0;
            load_ready_q  <= 1'b0;
            busy_q        <= 1'b1;
            wrapped_q     <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            wr_pend_q     <= 1'b0;
            instr_valid_q <= fetch_acc;
            unique case (state_q)
                StBoot: begin
                    boot_cnt_q <= boot_cnt_q + PC_WIDTH'(1);
                    if (boot_cnt_q == PC_WIDTH'(DEPTH - 1)) begin
                        state_q       <= StRun;
                        fetch_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                StRun: begin
                    if (load_start) begin
                        state_q       <= StLoad;
                        load_addr_q   <= load_addr;
                        wrapped_q     <= 1'b0;
                        byte_idx_q    <= '0;
                        asm_q         <= '0;
                        last_q        <= 1'b0;
                        fetch_ready_q <= 1'b0;
                        load_ready_q  <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                StLoad: begin
                    if (last_q) begin
                        // Final word is being written this cycle; resume fetching next.
                        state_q       <= StRun;
                        last_q        <= 1'b0;
                        fetch_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (byte_acc) begin
                        if (word_full || load_last) begin
                            wr_pend_q  <= 1'b1;
                            wr_addr_q  <= load_addr_q;
                            wr_data_q  <= asm_next;
                            asm_q      <= '0;
                            byte_idx_q <= '0;
                            if (load_last) begin
                                last_q       <= 1'b1;
                                load_ready_q <= 1'b0;
                            end else begin
                                load_addr_q <= addr_next;
                                if (addr_at_end) begin
                                    wrapped_q <= 1'b1;
                                end
                            end
                        end else begin
                            asm_q      <= asm_next;
                            byte_idx_q <= byte_idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= StBoot;
            endcase
        end
    end

    program_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (PC_WIDTH),
        .DATA_WIDTH (INSTRUCTION_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .re_i    (fetch_acc),
        .raddr_i (pc),
        .rdata_o (instruction)
    );

    assign fetch_ready       = fetch_ready_q;
    assign instruction_valid = instr_valid_q;
    assign load_ready        = load_ready_q;
    assign busy              = busy_q;
    assign load_wrapped      = wrapped_q;

endmodule

// File: tb/tb_program_memory.sv
// Scoreboard bench for program_memory: a default (DEPTH=16) instance and a DEPTH=12 instance.
module tb_program_memory;
    import puc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        fetch_req, load_start, load_valid, load_last;
    logic [3:0]  pc, load_addr;
    logic [7:0]  load_data;
    logic        fetch_ready, instruction_valid, load_ready, busy, load_wrapped;
    logic [15:0] instruction;

    logic        fetch_req12, load_start12, load_valid12, load_last12;
    logic [3:0]  pc12, load_addr12;
    logic [7:0]  load_data12;
    logic        fetch_ready12, instruction_valid12, load_ready12, busy12, load_wrapped12;
    logic [15:0] instruction12;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    logic [15:0] exp12_q[$];
    logic [15:0] exp_v;
    logic [15:0] exp12_v;

    program_memory dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_req         (fetch_req),
        .pc                (pc),
        .fetch_ready       (fetch_ready),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .load_start        (load_start),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .load_valid        (load_valid),
        .load_last         (load_last),
        .load_ready        (load_ready),
        .busy              (busy),
        .load_wrapped      (load_wrapped)
    );

    program_memory #(
        .PC_WIDTH          (4),
        .DEPTH             (12),
        .INSTRUCTION_WIDTH (16)
    ) dut12 (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_req         (fetch_req12),
        .pc                (pc12),
        .fetch_ready       (fetch_ready12),
        .instruction       (instruction12),
        .instruction_valid (instruction_valid12),
        .load_start        (load_start12),
        .load_addr         (load_addr12),
        .load_data         (load_data12),
        .load_valid        (load_valid12),
        .load_last         (load_last12),
        .load_ready        (load_ready12),
        .busy              (busy12),
        .load_wrapped      (load_wrapped12)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for the default instance: every valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (instruction_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected fetch result");
            end else begin
                exp_v = exp_q.pop_front();
                check("fetch", {16'h0, instruction}, {16'h0, exp_v});
            end
        end
    end

    always @(negedge clk) begin
        if (instruction_valid12 === 1'b1) begin
            if (exp12_q.size() == 0) begin
                fail_now("unexpected fetch result depth12");
            end else begin
                exp12_v = exp12_q.pop_front();
                check("fetch depth12", {16'h0, instruction12}, {16'h0, exp12_v});
            end
        end
    end

    task automatic fetch(input logic [3:0] p, input logic [15:0] e);
        fetch_req = 1'b1;
        pc        = p;
        exp_q.push_back(e);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic fetch12(input logic [3:0] p, input logic [15:0] e);
        fetch_req12 = 1'b1;
        pc12        = p;
        exp12_q.push_back(e);
        tick();
        fetch_req12 = 1'b0;
    endtask

    task automatic start_load(input logic [3:0] a);
        load_start = 1'b1;
        load_addr  = a;
        tick();
        load_start = 1'b0;
        check("load_ready after load_start", load_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        int n;
        n          = 0;
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        while (load_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) fail_now("load_ready wait");
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        fetch_req    = 1'b0; pc   = '0; load_start   = 1'b0; load_addr   = '0;
        load_data    = '0;   load_valid   = 1'b0; load_last   = 1'b0;
        fetch_req12  = 1'b0; pc12 = '0; load_start12 = 1'b0; load_addr12 = '0;
        load_data12  = '0;   load_valid12 = 1'b0; load_last12 = 1'b0;
        repeat (3) tick();

        check("reset instruction",       {16'h0, instruction}, 0);
        check("reset instruction_valid", instruction_valid, 0);
        check("reset fetch_ready",       fetch_ready, 0);
        check("reset load_ready",        load_ready, 0);
        check("reset load_wrapped",      load_wrapped, 0);
        check("reset busy",              busy, 1);

        // Release reset; the depth-12 instance sees load_start during its boot.
        rst_n        = 1'b1;
        load_start12 = 1'b1;
        load_addr12  = 4'd3;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 4) load_start12 = 1'b0;
            if (c == 3) begin
                check("depth12 load_ready during boot", load_ready12, 0);
                check("depth12 busy during boot", busy12, 1);
            end
            if (c == 11) check("depth12 busy cycle 11", busy12, 1);
            if (c == 12) begin
                check("depth12 busy cycle 12", busy12, 0);
                check("depth12 fetch_ready cycle 12", fetch_ready12, 1);
                check("depth12 load_ready after boot", load_ready12, 0);
            end
            if (c == 15) begin
                check("busy cycle 15", busy, 1);
                check("fetch_ready cycle 15", fetch_ready, 0);
            end
            if (c == 16) begin
                check("busy cycle 16", busy, 0);
                check("fetch_ready cycle 16", fetch_ready, 1);
                check("load_ready in run", load_ready, 0);
            end
        end

        fetch(4'd1, {LOADI, 3'd1, 8'h03});
        fetch(4'd5, {JUMP, 3'd1, 8'h04});
        fetch(4'd9, 16'h0000);
        fetch12(4'd13, 16'h0000);
        fetch12(4'd5, {JUMP, 3'd1, 8'h04});
        tick();

        // Load two bytes at 4; a fetch issued alongside load_start still completes.
        load_start = 1'b1;
        load_addr  = 4'd4;
        fetch_req  = 1'b1;
        pc         = 4'd3;
        exp_q.push_back({LOADI, 3'd1, 8'h01});
        tick();
        load_start = 1'b0;
        fetch_req  = 1'b0;
        check("load_ready after load_start", load_ready, 1);
        check("fetch_ready in load", fetch_ready, 0);
        check("busy in load", busy, 1);
        send_byte(8'h34, 1'b0);
        send_byte(8'h12, 1'b1);
        check("fetch_ready in write cycle", fetch_ready, 0);
        tick();
        check("fetch_ready after load", fetch_ready, 1);
        check("load_wrapped no wrap", load_wrapped, 0);
        fetch(4'd4, 16'h1234);
        tick();
        check("instruction hold", {16'h0, instruction}, 32'h1234);
        check("instruction_valid low", instruction_valid, 0);

        // Wrapping load at 15.
        start_load(4'd15);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h04, 1'b0);
        send_byte(8'h05, 1'b1);
        tick();
        check("fetch_ready after wrap load", fetch_ready, 1);
        check("load_wrapped set", load_wrapped, 1);
        fetch(4'd15, 16'h0201);
        fetch(4'd0, 16'h0403);
        fetch(4'd1, 16'h0005);
        tick();

        // Reset in the middle of a load.
        start_load(4'd2);
        send_byte(8'hAA, 1'b0);
        rst_n = 1'b0;
        tick();
        check("busy in reset", busy, 1);
        check("load_ready in reset", load_ready, 0);
        check("instruction in reset", {16'h0, instruction}, 0);
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c < 16) check("busy during reboot", busy, 1);
            else check("busy after reboot", busy, 0);
        end
        fetch(4'd2, {MOVE, 3'd1, 8'h00});
        fetch(4'd1, {LOADI, 3'd1, 8'h03});
        fetch(4'd0, 16'h0000);
        fetch(4'd8, {RESET, 3'd1, 8'h00});
        repeat (3) tick();

        check("scoreboard drained", exp_q.size(), 0);
        check("scoreboard drained depth12", exp12_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
